// File: rtl/next_pc_unit_pkg.sv
// Shared encodings for the next-PC unit: PC select codes and FSM states.
package next_pc_unit_pkg;

  localparam int unsigned PC_SEL_W = 2;
  localparam int unsigned STATE_W  = 2;

  // PC_TRAP takes the last code so the original three selects keep their values.
  typedef enum logic [PC_SEL_W-1:0] {
    PC_PLUS4 = 2'd0,
    PC_ALU   = 2'd1,
    PC_IMM   = 2'd2,
    PC_TRAP  = 2'd3
  } pc_sel_e;

  typedef enum logic [STATE_W-1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } npc_state_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Control/fetch-side bundle of the next-PC unit.
interface next_pc_unit_if #(
  parameter int unsigned XLEN = 32
);

  next_pc_unit_pkg::pc_sel_e pc_sel;
  logic                      redirect_valid;
  logic [XLEN-1:0]           alu_target;
  logic [XLEN-1:0]           imm;
  logic                      halt_req;
  logic                      pc_ready;
  logic                      pc_valid;
  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           pc_link;
  logic                      misalign_err;
  logic [XLEN-1:0]           bad_addr;

  // Pipeline control / fetch side
  modport master (
    output pc_sel, redirect_valid, alu_target, imm, halt_req, pc_ready,
    input  pc_valid, pc, pc_link, misalign_err, bad_addr
  );

  // Next-PC unit side
  modport slave (
    input  pc_sel, redirect_valid, alu_target, imm, halt_req, pc_ready,
    output pc_valid, pc, pc_link, misalign_err, bad_addr
  );

endinterface

// File: rtl/next_pc_unit_target_calc.sv
// Combinational redirect target computation and alignment check.
module pc_target_calc
  import next_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     IALIGN      = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
  input  logic [XLEN-1:0] pc_i,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] alu_target_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] link_c_o,
  output logic [XLEN-1:0] target_c_o,
  output logic [XLEN-1:0] redirect_pc_c_o,
  output logic            misalign_c_o
);

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] alu_clr;
  logic [XLEN-1:0] rel_target;

  // Wrapping adds for link and PC-relative targets; JALR drops bit 0.
  always_comb begin
    link_c_o   = pc_i + XLEN'(IALIGN);
    rel_target = pc_i + imm_i;
    alu_clr    = alu_target_i & ~XLEN'(1);
  end

  // Select the raw target, flag misalignment, substitute the trap vector on error.
  always_comb begin
    target_c_o   = link_c_o;
    misalign_c_o = 1'b0;
    case (pc_sel_i)
      PC_PLUS4: target_c_o = link_c_o;
      PC_ALU: begin
        target_c_o   = alu_clr;
        misalign_c_o = |(alu_clr & ALIGN_MASK);
      end
      PC_IMM: begin
        target_c_o   = rel_target;
        misalign_c_o = |(rel_target & ALIGN_MASK);
      end
      PC_TRAP: target_c_o = TRAP_VECTOR;
      default: target_c_o = link_c_o;
    endcase
    redirect_pc_c_o = misalign_c_o ? TRAP_VECTOR : target_c_o;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, redirects and misalignment capture.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     IALIGN       = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input logic          clk,
  input logic          rst_n,
  next_pc_unit_if.slave bus
);

  npc_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic [XLEN-1:0] link_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic            misalign_c;

  pc_target_calc #(
    .XLEN        (XLEN),
    .IALIGN      (IALIGN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_calc (
    .pc_i            (pc_q),
    .pc_sel_i        (bus.pc_sel),
    .alu_target_i    (bus.alu_target),
    .imm_i           (bus.imm),
    .link_c_o        (link_c),
    .target_c_o      (target_c),
    .redirect_pc_c_o (redirect_pc_c),
    .misalign_c_o    (misalign_c)
  );

  // State and output registers; reset drops any pending redirect or halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Next state, next PC and error capture; redirects apply in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;

    if (bus.redirect_valid) begin
      pc_d = redirect_pc_c;
      if (misalign_c) begin
        misalign_d = 1'b1;
        bad_addr_d = target_c;
      end
    end else if (pc_valid_q && bus.pc_ready) begin
      pc_d = link_c;
    end

    case (state_q)
      BOOT:    state_d = bus.halt_req ? HALT : RUN;
      RUN:     if (bus.halt_req) state_d = HALT;
      HALT:    if (!bus.halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase

    pc_valid_d = (state_d == RUN);
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.bad_addr     = bad_addr_q;
  assign bus.pc_link      = link_c;

endmodule
